seg7_scan: RTL and testbench

//  Four-digit multiplexed hex display driver; the downstream stage of MEMORY.

---
 rtl/seg7_scan_if.sv | 10 +
 rtl/seg7_scan.sv | 126 ++++++++++++
 tb/tb_seg7_scan.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - store/readback port between MEMORY and seg7_scan
interface seg7_scan_if;
  logic        wr_en_i;
  logic        wr_sel_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output wr_en_i, output wr_sel_i, output wdata_i, input rdata_o);
  modport slave  (input wr_en_i, input wr_sel_i, input wdata_i, output rdata_o);
endinterface

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - four-digit multiplexed hex display driver with frame-shadowed registers
module seg7_scan #(
  parameter int CLK_DIV = 100000,
  parameter int CNT_W   = 17
) (
  input  logic        clk,
  input  logic        rst,
  seg7_scan_if.slave  bus,
  output logic [6:0]  seg7_seg_o,
  output logic [3:0]  seg7_an_o
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [8:0]       LP_CTRL_RST = 9'h0F1;

  logic [15:0]      r_data;
  logic [8:0]       r_ctrl;
  logic [15:0]      r_sh_data;
  logic             r_sh_lzb;
  logic [3:0]       r_sh_mask;
  logic             r_sh_en;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;

  logic             w_tick;
  logic             w_frame;
  logic [3:0]       w_shift;
  logic [3:0]       w_nib;
  logic             w_upper_zero;
  logic             w_blank;
  logic [3:0]       w_an;
  logic [6:0]       w_hex;
  logic             w_unused;

  assign w_tick   = (r_cnt == LP_CNT_MAX);
  assign w_frame  = w_tick && (r_idx == 2'd3);
  assign w_unused = &{1'b0, bus.wdata_i[31:16]};

  // Register file: DATA and CTRL stores, one target per strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 16'h0000;
      r_ctrl <= LP_CTRL_RST;
    end else if (bus.wr_en_i) begin
      if (bus.wr_sel_i) r_ctrl <= bus.wdata_i[8:0];
      else              r_data <= bus.wdata_i[15:0];
    end
  end

  assign bus.rdata_o = bus.wr_sel_i ? {23'd0, r_ctrl} : {16'd0, r_data};

  // Prescaler and digit index; idx wrapping 3->0 marks the frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // Shadow copy taken on the first clock after reset and at every frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first   <= 1'b1;
      r_sh_data <= 16'h0000;
      r_sh_lzb  <= LP_CTRL_RST[8];
      r_sh_mask <= LP_CTRL_RST[7:4];
      r_sh_en   <= LP_CTRL_RST[0];
    end else begin
      r_first <= 1'b0;
      if (r_first || w_frame) begin
        r_sh_data <= r_data;
        r_sh_lzb  <= r_ctrl[8];
        r_sh_mask <= r_ctrl[7:4];
        r_sh_en   <= r_ctrl[0];
      end
    end
  end

  // Digit selection, blanking and hex decode for the current slot
  always_comb begin
    w_shift      = {r_idx, 2'b00};
    w_nib        = r_sh_data[w_shift +: 4];
    w_upper_zero = ((r_sh_data >> w_shift) == 16'h0000);
    w_blank      = !r_sh_mask[r_idx] || (r_sh_lzb && w_upper_zero && (r_idx != 2'd0));
    w_an         = ~((4'b0001 << r_idx) & r_sh_mask);
    w_hex        = 7'h7F;
    case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
      default: w_hex = 7'h7F;
    endcase
  end

  // Registered pins; disabled display stays fully dark while counters run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg7_an_o  <= 4'hF;
      seg7_seg_o <= 7'h7F;
    end else if (!r_sh_en) begin
      seg7_an_o  <= 4'hF;
      seg7_seg_o <= 7'h7F;
    end else begin
      seg7_an_o  <= w_an;
      seg7_seg_o <= w_blank ? 7'h7F : w_hex;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a frame-level reference model
module tb_seg7_scan;
  localparam int D = 4;
  localparam int FRAME = 4 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] w_seg;
  logic [3:0] w_an;

  seg7_scan_if bus ();

  seg7_scan #(.CLK_DIV(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .seg7_seg_o (w_seg),
    .seg7_an_o  (w_an)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          checks = 0;
  int          failures = 0;
  int          k = 0;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_sh_data = 16'h0;
  logic [8:0]  m_ctrl = 9'h0F1;
  logic [8:0]  m_sh_ctrl = 9'h0F1;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;

  task automatic model_reset();
    k = 0;
    m_data = 16'h0;
    m_sh_data = 16'h0;
    m_ctrl = 9'h0F1;
    m_sh_ctrl = 9'h0F1;
    exp_an = 4'hF;
    exp_seg = 7'h7F;
  endtask

  // One clock: apply a store, then derive the expected pins for edge k from the shadow state
  task automatic step(input logic we, input logic sel, input logic [31:0] wd);
    int idx;
    logic [3:0] nib;
    logic blank;
    bus.wr_en_i = we;
    bus.wr_sel_i = sel;
    bus.wdata_i = wd;
    @(posedge clk);
    k = k + 1;
    idx = ((k - 1) / D) % 4;
    nib = 4'((m_sh_data >> (4 * idx)) & 16'hF);
    blank = (m_sh_ctrl[4 + idx] == 1'b0) ||
            (m_sh_ctrl[8] && idx != 0 && (m_sh_data >> (4 * idx)) == 0);
    if (!m_sh_ctrl[0] || !m_sh_ctrl[4 + idx]) exp_an = 4'hF;
    else exp_an = ~(4'b0001 << idx);
    if (!m_sh_ctrl[0] || blank) exp_seg = 7'h7F;
    else exp_seg = hex_tab[nib];
    if (k == 1 || (k % FRAME) == 0) begin
      m_sh_data = m_data;
      m_sh_ctrl = m_ctrl;
    end
    if (we) begin
      if (sel) m_ctrl = wd[8:0];
      else     m_data = wd[15:0];
    end
    #1;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic apply_reset();
    bus.wr_en_i = 1'b0;
    bus.wr_sel_i = 1'b0;
    bus.wdata_i = 32'h0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.wr_en_i = 1'b0;
    bus.wr_sel_i = 1'b0;
    bus.wdata_i = 32'h0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w_an !== 4'hF || w_seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset_hold an=%h seg=%h expected an=F seg=7F", w_an, w_seg);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (w_an !== 4'hE || w_seg !== 7'h40) begin
      failures++;
      $display("FAIL reset_release an=%h seg=%h expected an=E seg=40", w_an, w_seg);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL reset_scan k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_data_write();
    while ((k % FRAME) != 5) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'hABCD1234);
    bus.wr_sel_i = 1'b0;
    #1;
    checks++;
    if (bus.rdata_o !== 32'h0000_1234) begin
      failures++;
      $display("FAIL data_readback rdata=%h expected=00001234", bus.rdata_o);
    end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL data_write k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_boundary_write();
    logic [31:0] v;
    v = $urandom;
    while ((k % FRAME) != FRAME - 1) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, v);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL boundary_write k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_lzb();
    step(1'b1, 1'b1, 32'h0000_01F1);
    step(1'b1, 1'b0, 32'h0000_0005);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL lzb_five k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
    step(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL lzb_zero k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_mask_enable();
    step(1'b1, 1'b0, 32'h0000_9E7C);
    step(1'b1, 1'b1, 32'h0000_0051);
    bus.wr_sel_i = 1'b1;
    #1;
    checks++;
    if (bus.rdata_o !== 32'h0000_0051) begin
      failures++;
      $display("FAIL ctrl_readback rdata=%h expected=00000051", bus.rdata_o);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL mask k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
    step(1'b1, 1'b1, 32'h0000_0050);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL disable k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_random();
    logic we;
    logic sel;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      we = ($urandom_range(0, 5) == 0);
      sel = $urandom_range(0, 1) == 1;
      wd = $urandom;
      if (sel && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      step(we, sel, wd);
      checks++;
      if (w_an !== exp_an || w_seg !== exp_seg) begin
        failures++;
        $display("FAIL random k=%0d an=%h seg=%h expected an=%h seg=%h", k, w_an, w_seg, exp_an, exp_seg);
      end
      bus.wr_sel_i = $urandom_range(0, 1) == 1;
      #1;
      checks++;
      if (bus.rdata_o !== (bus.wr_sel_i ? {23'd0, m_ctrl} : {16'd0, m_data})) begin
        failures++;
        $display("FAIL random_rdata sel=%0b rdata=%h expected=%h", bus.wr_sel_i, bus.rdata_o,
                 bus.wr_sel_i ? {23'd0, m_ctrl} : {16'd0, m_data});
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    step(1'b1, 1'b1, 32'h0000_00F1);
    step(1'b1, 1'b0, 32'h0000_4321);
    while ((k % FRAME) != 2 * D + 1) step(1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (w_an !== 4'hF || w_seg !== 7'h7F) begin
      failures++;
      $display("FAIL reset_async an=%h seg=%h expected an=F seg=7F", w_an, w_seg);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2 * D; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (w_an !== ((i < D) ? 4'hE : 4'hD) || w_seg !== 7'h40) begin
        failures++;
        $display("FAIL reset_restart i=%0d an=%h seg=%h expected an=%h seg=40", i, w_an, w_seg,
                 (i < D) ? 4'hE : 4'hD);
      end
    end
  endtask

  initial begin
    bus.wr_en_i = 1'b0;
    bus.wr_sel_i = 1'b0;
    bus.wdata_i = 32'h0;
    test_reset();
    test_data_write();
    test_boundary_write();
    test_lzb();
    test_mask_enable();
    apply_reset();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
